// File: rtl/sample_loop_buffer.sv
// Circular sample RAM controller: bypass, record, loop playback and delay/echo.
// Two-cycle registered latency from an accepted in_valid to out_valid in every mode.
module sample_loop_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   delay_len,
    input  logic [7:0]          gain,
    input  logic                clr_status,
    output logic [DATA_W-1:0]   sample_out,
    output logic                out_valid,
    output logic                busy,
    output logic                full,
    output logic [ADDR_W:0]     loop_len,
    output logic                overrun
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned PROD_W = DATA_W + 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RECORD = 2'b01,
        ST_LOOP   = 2'b10,
        ST_DELAY  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SEL_IN  = 2'b00,
        SEL_MEM = 2'b01,
        SEL_MIX = 2'b10
    } sel_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   dly_ptr_q, dly_ptr_d;
    logic [ADDR_W-1:0]   prime_q, prime_d;
    logic [LEN_W-1:0]    loop_len_q, loop_len_d;
    logic                full_q, full_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic                s1_valid_q, s1_valid_d;
    sel_t                s1_sel_q, s1_sel_d;
    logic                s1_mem_en_q, s1_mem_en_d;
    logic [DATA_W-1:0]   s1_sample_q, s1_sample_d;
    logic [7:0]          s1_gain_q, s1_gain_d;
    logic [DATA_W-1:0]   sample_out_q, sample_out_d;
    logic                out_valid_q, out_valid_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data_q;

    logic                accept_c;
    logic                entering_c;
    logic                mem_we_c, mem_re_c;
    logic [ADDR_W-1:0]   mem_waddr_c, mem_raddr_c;
    logic [ADDR_W-1:0]   wr_eff_c, rd_eff_c, dly_eff_c, prime_eff_c;
    logic [LEN_W-1:0]    len_eff_c;
    logic                full_eff_c;

    logic [DATA_W-1:0]        delayed_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] sum_c;
    logic [DATA_W-1:0]        mix_c;
    logic [DATA_W-1:0]        result_c;

    assign accept_c = in_valid && !busy_q;

    // Stage 0: mode tracking, pointer bookkeeping and memory access for an accepted sample
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dly_ptr_d   = dly_ptr_q;
        prime_d     = prime_q;
        loop_len_d  = loop_len_q;
        full_d      = full_q;
        s1_sel_d    = s1_sel_q;
        s1_mem_en_d = s1_mem_en_q;
        s1_sample_d = s1_sample_q;
        s1_gain_d   = s1_gain_q;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        mem_waddr_c = '0;
        mem_raddr_c = '0;
        entering_c  = 1'b0;
        wr_eff_c    = wr_ptr_q;
        rd_eff_c    = rd_ptr_q;
        dly_eff_c   = dly_ptr_q;
        prime_eff_c = prime_q;
        len_eff_c   = loop_len_q;
        full_eff_c  = full_q;

        if (accept_c) begin
            state_d     = state_t'(mode);
            entering_c  = (state_d != state_q);
            s1_sample_d = sample_in;
            s1_gain_d   = gain;
            s1_sel_d    = SEL_IN;
            s1_mem_en_d = 1'b0;

            case (state_d)
                ST_RECORD: begin
                    wr_eff_c   = entering_c ? '0 : wr_ptr_q;
                    len_eff_c  = entering_c ? '0 : loop_len_q;
                    full_eff_c = entering_c ? 1'b0 : full_q;
                    wr_ptr_d   = wr_eff_c;
                    loop_len_d = len_eff_c;
                    full_d     = full_eff_c;
                    if (!full_eff_c) begin
                        mem_we_c    = 1'b1;
                        mem_waddr_c = wr_eff_c;
                        wr_ptr_d    = wr_eff_c + ADDR_W'(1);
                        loop_len_d  = len_eff_c + LEN_W'(1);
                        full_d      = ((len_eff_c + LEN_W'(1)) == LEN_W'(DEPTH));
                    end
                end
                ST_LOOP: begin
                    rd_eff_c = entering_c ? '0 : rd_ptr_q;
                    rd_ptr_d = rd_eff_c;
                    if (loop_len_q != '0) begin
                        mem_re_c    = 1'b1;
                        mem_raddr_c = rd_eff_c;
                        s1_sel_d    = SEL_MEM;
                        rd_ptr_d    = ((LEN_W'(rd_eff_c) + LEN_W'(1)) == loop_len_q)
                                      ? '0 : rd_eff_c + ADDR_W'(1);
                    end
                end
                ST_DELAY: begin
                    dly_eff_c   = entering_c ? '0 : dly_ptr_q;
                    prime_eff_c = entering_c ? '0 : prime_q;
                    mem_we_c    = 1'b1;
                    mem_waddr_c = dly_eff_c;
                    dly_ptr_d   = dly_eff_c + ADDR_W'(1);
                    s1_sel_d    = SEL_MIX;
                    // Only read once the line holds delay_len real samples
                    if ((delay_len != '0) && (prime_eff_c >= delay_len)) begin
                        mem_re_c    = 1'b1;
                        mem_raddr_c = dly_eff_c - delay_len;
                        s1_mem_en_d = 1'b1;
                    end
                    prime_d = (prime_eff_c < delay_len) ? prime_eff_c + ADDR_W'(1) : prime_eff_c;
                end
                default: ;
            endcase
        end
    end

    // Handshake and sticky status
    always_comb begin
        s1_valid_d = accept_c;
        busy_d     = accept_c || s1_valid_q;
        overrun_d  = overrun_q;
        if (in_valid && busy_q) begin
            overrun_d = 1'b1;
        end else if (clr_status) begin
            overrun_d = 1'b0;
        end
    end

    // Stage 1: gain-scaled delayed mix with saturation and output select
    always_comb begin
        delayed_c = s1_mem_en_q ? rd_data_q : '0;
        prod_c    = $signed({{9{delayed_c[DATA_W-1]}}, delayed_c})
                  * $signed({{(DATA_W+1){1'b0}}, s1_gain_q});
        sum_c     = $signed({{9{s1_sample_q[DATA_W-1]}}, s1_sample_q}) + (prod_c >>> 8);
        if (!sum_c[PROD_W-1] && (sum_c[PROD_W-2:DATA_W-1] != '0)) begin
            mix_c = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sum_c[PROD_W-1] && !(&sum_c[PROD_W-2:DATA_W-1])) begin
            mix_c = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            mix_c = sum_c[DATA_W-1:0];
        end

        case (s1_sel_q)
            SEL_MEM: result_c = rd_data_q;
            SEL_MIX: result_c = mix_c;
            default: result_c = s1_sample_q;
        endcase

        out_valid_d  = s1_valid_q;
        sample_out_d = s1_valid_q ? result_c : sample_out_q;
    end

    // Sample RAM with registered read; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= sample_in;
        end
        if (mem_re_c) begin
            rd_data_q <= mem[mem_raddr_c];
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dly_ptr_q    <= '0;
            prime_q      <= '0;
            loop_len_q   <= '0;
            full_q       <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_sel_q     <= SEL_IN;
            s1_mem_en_q  <= 1'b0;
            s1_sample_q  <= '0;
            s1_gain_q    <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dly_ptr_q    <= dly_ptr_d;
            prime_q      <= prime_d;
            loop_len_q   <= loop_len_d;
            full_q       <= full_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            s1_valid_q   <= s1_valid_d;
            s1_sel_q     <= s1_sel_d;
            s1_mem_en_q  <= s1_mem_en_d;
            s1_sample_q  <= s1_sample_d;
            s1_gain_q    <= s1_gain_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign full       = full_q;
    assign loop_len   = loop_len_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/sample_loop_buffer.md
# sample_loop_buffer

Parametrised audio sample memory controller for the guitar pedal datapath: a single-port-per-cycle circular sample RAM with four runtime modes (bypass, record, loop playback, delay/echo). It sits between the ADC-side sample stream and the effect chain, driven by a one-cycle sample strobe at audio rate. Mode and effect controls come from the MCU-written config registers. It generalises the fixed record/loop controller with configurable width and depth, a mixed delay mode with gain, and explicit status flags.

## Interface
- DATA_W, 16, sample width, signed two's complement
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle strobe, sample_in valid
- sample_in  in  DATA_W  input sample
- mode  in  2  00 BYPASS, 01 RECORD, 10 LOOP, 11 DELAY
- delay_len  in  ADDR_W  delay in samples (DELAY mode)
- gain  in  8  delayed-path gain, unsigned Q0.8 (255 = 255/256)
- clr_status  in  1  clears sticky overrun
- sample_out  out  DATA_W  output sample
- out_valid  out  1  one-cycle strobe, sample_out valid
- busy  out  1  high while a sample is in flight
- full  out  1  record buffer holds DEPTH samples
- loop_len  out  ADDR_W+1  number of recorded samples, 0..DEPTH
- overrun  out  1  sticky: in_valid arrived while busy

## Operation
- States: IDLE, RECORD, LOOP, DELAY (BYPASS = IDLE). mode is sampled only on an accepted in_valid; state follows it on that cycle.
- Entering RECORD from any other state: wr_ptr=0, loop_len=0, full=0, before the accepted sample is written.
- Entering LOOP: rd_ptr=0. Entering DELAY: ptr=0, prime count=0.
- IDLE: sample_out = sample_in. No memory access.
- RECORD: if !full, write sample_in at wr_ptr, wr_ptr++, loop_len++; full=1 when loop_len reaches DEPTH; further samples not written. sample_out = sample_in (monitor).
- LOOP: if loop_len==0, sample_out = sample_in. Else sample_out = mem[rd_ptr]; rd_ptr wraps from loop_len-1 to 0. Input ignored, memory not written.
- DELAY: read mem[(ptr - delay_len) mod DEPTH], write sample_in at ptr, ptr wraps DEPTH-1 -> 0. delayed = 0 if delay_len==0 or prime count < delay_len (prime count saturates at delay_len). sample_out = sat(sample_in + ((delayed * gain) >>> 8)); product DATA_W+9 bits signed, arithmetic shift, sum saturates to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- delay_len and gain sampled with in_valid; changes take effect next sample.
- overrun set on in_valid while busy (that sample dropped); cleared by clr_status; set wins if both same cycle.
- Memory contents are never reset.

## Timing
- Accepted in_valid at cycle T: memory read issued/written in T (registered read); result computed in T+1; sample_out and out_valid registered at T+2. Latency 2 cycles in all modes, including IDLE.
- busy high in T+1 and T+2; next in_valid accepted at T+3 or later.
- loop_len, full, pointers update at T+1.
- Read and write in same cycle hit different addresses (delay_len>=1); delay_len==0 takes the zero-delayed path, no read-before-write ambiguity.
- Reset (async assert, any time incl. mid-sample): sample_out=0, out_valid=0, busy=0, full=0, loop_len=0, overrun=0, state IDLE, all pointers 0; in-flight sample discarded.

## Test plan
- DATA_W=16, ADDR_W=4. IDLE: in_valid with 0x1234 -> out_valid 2 cycles later, sample_out=0x1234, busy for 2 cycles.
- RECORD 5 samples 1..5, then LOOP 12 samples -> outputs 1,2,3,4,5,1,2,3,4,5,1,2; loop_len=5, full=0.
- RECORD 20 samples 1..20 -> full=1 after 16th, loop_len=16; LOOP output 1..16 then 1 again.
- DELAY, delay_len=3, gain=128, inputs 100,0,0,0,0 -> outputs 100,0,0,50,0; gain=255 with inputs 32767 then 32767 three later -> output saturates at 32767; -32768 case saturates at -32768.
- in_valid at T and T+1 -> second dropped, overrun=1 stays until clr_status; simultaneous new overrun and clr_status -> overrun=1.
- rstb low at T+1 of a RECORD sample -> no out_valid, loop_len=0, full=0, all outputs 0; LOOP after reset passes input through.
